main_mem_arbiter: RTL and testbench



---
 rtl/main_mem_arbiter_pkg.sv | 56 +++++
 rtl/main_mem_arb_pick.sv | 19 +
 rtl/main_mem_arbiter.sv | 111 +++++++++++
 tb/tb_main_mem_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_arbiter_pkg.sv
// Shared Frost32 memory-interface types plus the arbiter's own state and
// requester bundles.
package PkgFrost32Cpu;
  typedef enum logic {
    DiatRead  = 1'b0,
    DiatWrite = 1'b1
  } DataInoutAccessType;

  // Dias32 encodes as 0 so an all-zero request is a plain 32-bit read.
  typedef enum logic [1:0] {
    Dias32 = 2'd0,
    Dias16 = 2'd1,
    Dias8  = 2'd2
  } DataInoutAccessSize;
endpackage

package PkgMainMem;
  import PkgFrost32Cpu::*;

  typedef struct packed {
    logic               req_mem_access;
    logic [31:0]        addr;
    logic [31:0]        data;
    DataInoutAccessType access_type;
    DataInoutAccessSize access_size;
  } PortIn_MainMem;

  typedef struct packed {
    logic [31:0] data;
  } PortOut_MainMem;
endpackage

package PkgMainMemArbiter;
  import PkgFrost32Cpu::*;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } State;

  typedef struct packed {
    logic               req;
    logic [31:0]        addr;
    logic [31:0]        data;
    DataInoutAccessType access_type;
    DataInoutAccessSize access_size;
  } PortIn_Requester;

  typedef struct packed {
    logic        ack;
    logic [31:0] rdata;
  } PortOut_Requester;
endpackage

// File: rtl/main_mem_arb_pick.sv
// Combinational winner select between the fetch (0) and data (1) requesters.
module main_mem_arb_pick #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic any_req,
  output logic winner
);

  always_comb begin
    any_req = req0 | req1;
    winner  = req1;
    // On contention, round-robin favours whoever did not win last time.
    if (req0 && req1) winner = ROUND_ROBIN ? ~last_grant : 1'b1;
  end

endmodule

// File: rtl/main_mem_arbiter.sv
// Two-port arbiter in front of the single-ported MainMem; every granted
// access runs IDLE -> ISSUE -> RESP and acks in RESP.
module main_mem_arbiter
  import PkgFrost32Cpu::*;
  import PkgMainMem::*;
  import PkgMainMemArbiter::*;
#(
  parameter bit ROUND_ROBIN      = 1'b1,
  parameter bit RESET_LAST_GRANT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic [31:0]        addr0,
  input  logic [31:0]        wdata0,
  input  DataInoutAccessType type0,
  input  DataInoutAccessSize size0,
  output logic               ack0,
  output logic [31:0]        rdata0,
  input  logic               req1,
  input  logic [31:0]        addr1,
  input  logic [31:0]        wdata1,
  input  DataInoutAccessType type1,
  input  DataInoutAccessSize size1,
  output logic               ack1,
  output logic [31:0]        rdata1,
  output PortIn_MainMem      mem_in,
  input  PortOut_MainMem     mem_out
);

  PortIn_Requester  [NUM_PORTS-1:0] rq;
  PortOut_Requester [NUM_PORTS-1:0] rsp;

  State                 state;
  logic                 last_grant;
  logic                 grant;
  logic [NUM_PORTS-1:0] ack_q;
  logic                 any_req;
  logic                 winner;

  assign rq[0] = '{req: req0, addr: addr0, data: wdata0,
                   access_type: type0, access_size: size0};
  assign rq[1] = '{req: req1, addr: addr1, data: wdata1,
                   access_type: type1, access_size: size1};

  main_mem_arb_pick #(
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_pick (
    .req0      (rq[0].req),
    .req1      (rq[1].req),
    .last_grant(last_grant),
    .any_req   (any_req),
    .winner    (winner)
  );

  // MainMem already registers its read data, so it is steered straight out.
  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
      assign rsp[p] = '{ack: ack_q[p],
                        rdata: (state == StResp && grant == 1'(p)) ? mem_out.data : 32'h0};
    end
  endgenerate

  assign ack0   = rsp[0].ack;
  assign rdata0 = rsp[0].rdata;
  assign ack1   = rsp[1].ack;
  assign rdata1 = rsp[1].rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      last_grant <= RESET_LAST_GRANT;
      grant      <= 1'b0;
      ack_q      <= '0;
      mem_in     <= '0;
    end else begin
      case (state)
        StIdle: begin
          ack_q <= '0;
          mem_in.req_mem_access <= 1'b0;
          if (any_req) begin
            // Latch the winner's request; requester inputs are ignored from here on.
            mem_in <= '{req_mem_access: 1'b1,
                        addr:           rq[winner].addr,
                        data:           rq[winner].data,
                        access_type:    rq[winner].access_type,
                        access_size:    rq[winner].access_size};
            grant      <= winner;
            last_grant <= winner;
            state      <= StIssue;
          end
        end
        StIssue: begin
          mem_in.req_mem_access <= 1'b0;
          ack_q[grant]          <= 1'b1;
          state                 <= StResp;
        end
        StResp: begin
          ack_q <= '0;
          state <= StIdle;
        end
        default: begin
          ack_q <= '0;
          mem_in.req_mem_access <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Bench for main_mem_arbiter: a round-robin and a fixed-priority instance,
// each backed by a big-endian MainMem model, plus a transaction-level reference.
module tb_main_mem_arbiter;
  import PkgFrost32Cpu::*;
  import PkgMainMem::*;

  logic               clk, reset;
  logic               req0, req1;
  logic [31:0]        addr0, addr1, wdata0, wdata1;
  DataInoutAccessType type0, type1;
  DataInoutAccessSize size0, size1;

  logic               ack0_a, ack1_a, ack0_b, ack1_b;
  logic [31:0]        rdata0_a, rdata1_a, rdata0_b, rdata1_b;
  PortIn_MainMem      mem_in_a, mem_in_b;
  PortOut_MainMem     mem_out_a, mem_out_b;

  // [0] backs dut_a, [1] backs dut_b, [2] is the reference copy for dut_a.
  logic [7:0] mm [0:2][0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  main_mem_arbiter #(.ROUND_ROBIN(1'b1), .RESET_LAST_GRANT(1'b1)) dut_a (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .type0(type0), .size0(size0),
    .ack0(ack0_a), .rdata0(rdata0_a),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .type1(type1), .size1(size1),
    .ack1(ack1_a), .rdata1(rdata1_a),
    .mem_in(mem_in_a), .mem_out(mem_out_a));

  main_mem_arbiter #(.ROUND_ROBIN(1'b0), .RESET_LAST_GRANT(1'b1)) dut_b (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .type0(type0), .size0(size0),
    .ack0(ack0_b), .rdata0(rdata0_b),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .type1(type1), .size1(size1),
    .ack1(ack1_b), .rdata1(rdata1_b),
    .mem_in(mem_in_b), .mem_out(mem_out_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mm_read(int w, logic [31:0] a, DataInoutAccessSize s);
    logic [15:0] b0, b1, b2, b3;
    b0 = a[15:0]; b1 = b0 + 16'd1; b2 = b0 + 16'd2; b3 = b0 + 16'd3;
    case (s)
      Dias32:  return {mm[w][b0], mm[w][b1], mm[w][b2], mm[w][b3]};
      Dias16:  return {16'h0, mm[w][b0], mm[w][b1]};
      default: return {24'h0, mm[w][b0]};
    endcase
  endfunction

  function automatic void mm_write(int w, logic [31:0] a, logic [31:0] d, DataInoutAccessSize s);
    logic [15:0] b0, b1, b2, b3;
    b0 = a[15:0]; b1 = b0 + 16'd1; b2 = b0 + 16'd2; b3 = b0 + 16'd3;
    case (s)
      Dias32: begin
        mm[w][b0] = d[31:24]; mm[w][b1] = d[23:16];
        mm[w][b2] = d[15:8];  mm[w][b3] = d[7:0];
      end
      Dias16: begin
        mm[w][b0] = d[15:8]; mm[w][b1] = d[7:0];
      end
      default: mm[w][b0] = d[7:0];
    endcase
  endfunction

  // MainMem: samples the request at the edge closing ISSUE, read data registered.
  always @(posedge clk) begin
    if (mem_in_a.req_mem_access) begin
      if (mem_in_a.access_type == DiatWrite)
        mm_write(0, mem_in_a.addr, mem_in_a.data, mem_in_a.access_size);
      else
        mem_out_a.data <= mm_read(0, mem_in_a.addr, mem_in_a.access_size);
    end
    if (mem_in_b.req_mem_access) begin
      if (mem_in_b.access_type == DiatWrite)
        mm_write(1, mem_in_b.addr, mem_in_b.data, mem_in_b.access_size);
      else
        mem_out_b.data <= mm_read(1, mem_in_b.addr, mem_in_b.access_size);
    end
  end

  task automatic set_port(int p, logic r, logic [31:0] a, logic [31:0] d,
                          DataInoutAccessType t, DataInoutAccessSize s);
    if (p == 0) begin
      req0 = r; addr0 = a; wdata0 = d; type0 = t; size0 = s;
    end else begin
      req1 = r; addr1 = a; wdata1 = d; type1 = t; size1 = s;
    end
  endtask

  // Leaves the bench at a negedge with both DUTs freshly out of reset in IDLE.
  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_port(0, 1'b0, 32'h0, 32'h0, DiatRead, Dias32);
    set_port(1, 1'b0, 32'h0, 32'h0, DiatRead, Dias32);
    reset = 1'b1;
    #1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ack0_a, ack1_a, ack0_b, ack1_b} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ack: got %b expected 0000", {ack0_a, ack1_a, ack0_b, ack1_b});
    end
    n_checks++;
    if ({rdata0_a, rdata1_a, rdata0_b, rdata1_b} !== 128'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h %h %h %h expected 0", rdata0_a, rdata1_a, rdata0_b, rdata1_b);
    end
    n_checks++;
    if (mem_in_a !== '0 || mem_in_b !== '0) begin
      n_fail++; $display("FAIL reset_mem_in: got %h / %h expected 0", mem_in_a, mem_in_b);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    set_port(1, 1'b1, 32'h10, 32'h0, DiatRead, Dias32);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      n_checks++;
      if (ack1_a !== 1'(c == 2) || ack0_a !== 1'b0) begin
        n_fail++; $display("FAIL single_read_ack c=%0d: got ack0=%b ack1=%b expected ack0=0 ack1=%b", c, ack0_a, ack1_a, c == 2);
      end
      if (c == 2) begin
        n_checks++;
        if (rdata1_a !== 32'h11223344) begin
          n_fail++; $display("FAIL single_read_data: got %h expected 11223344", rdata1_a);
        end
        req1 = 1'b0;
      end
    end
  endtask

  task automatic test_write_read();
    do_reset();
    set_port(1, 1'b1, 32'h20, 32'hDEADBEEF, DiatWrite, Dias32);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      n_checks++;
      if (ack1_a !== 1'(c == 2 || c == 5)) begin
        n_fail++; $display("FAIL write_read_ack c=%0d: got %b expected %b", c, ack1_a, c == 2 || c == 5);
      end
      if (c == 2) set_port(1, 1'b1, 32'h22, 32'h0, DiatRead, Dias16);
      if (c == 5) begin
        n_checks++;
        if (rdata1_a !== 32'h0000BEEF) begin
          n_fail++; $display("FAIL write_read_data: got %h expected 0000beef", rdata1_a);
        end
        req1 = 1'b0;
      end
    end
  endtask

  // Both ports contend; dut_a alternates, dut_b always serves port 1.
  task automatic test_contention();
    logic e0a, e1a, e0b, e1b;
    do_reset();
    set_port(0, 1'b1, 32'h10, 32'h0, DiatRead, Dias32);
    set_port(1, 1'b1, 32'h20, 32'h0, DiatRead, Dias32);
    for (int c = 0; c < 17; c++) begin
      if (c > 0) @(negedge clk);
      e0a = c inside {2, 8, 14};
      e1a = c inside {5, 11};
      e0b = (c == 14);
      e1b = c inside {2, 5, 8, 11};
      n_checks++;
      if (ack0_a !== e0a || ack1_a !== e1a) begin
        n_fail++; $display("FAIL rr_ack c=%0d: got %b%b expected %b%b", c, ack0_a, ack1_a, e0a, e1a);
      end
      n_checks++;
      if (ack0_b !== e0b || ack1_b !== e1b) begin
        n_fail++; $display("FAIL fixed_ack c=%0d: got %b%b expected %b%b", c, ack0_b, ack1_b, e0b, e1b);
      end
      if (e0a) begin
        n_checks++;
        if (rdata0_a !== 32'h11223344 || rdata1_a !== 32'h0) begin
          n_fail++; $display("FAIL rr_rdata0 c=%0d: got %h/%h expected 11223344/0", c, rdata0_a, rdata1_a);
        end
      end
      if (e1a) begin
        n_checks++;
        if (rdata1_a !== 32'hDEADBEEF || rdata0_a !== 32'h0) begin
          n_fail++; $display("FAIL rr_rdata1 c=%0d: got %h/%h expected deadbeef/0", c, rdata1_a, rdata0_a);
        end
      end
      if (c == 11) req1 = 1'b0;
      if (c == 14) req0 = 1'b0;
    end
  endtask

  task automatic test_input_churn();
    do_reset();
    set_port(0, 1'b1, 32'h10, 32'h0, DiatRead, Dias32);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if (mem_in_a.req_mem_access !== 1'b1 || mem_in_a.addr !== 32'h10) begin
          n_fail++; $display("FAIL churn_issue: got req=%b addr=%h expected 1/10", mem_in_a.req_mem_access, mem_in_a.addr);
        end
        addr0 = 32'h40;
        #2;
        n_checks++;
        if (mem_in_a.addr !== 32'h10) begin
          n_fail++; $display("FAIL churn_hold: got addr=%h expected 10", mem_in_a.addr);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (ack0_a !== 1'b1 || rdata0_a !== 32'h11223344) begin
          n_fail++; $display("FAIL churn_data: got ack=%b rdata=%h expected 1/11223344", ack0_a, rdata0_a);
        end
        n_checks++;
        if (mem_in_a.req_mem_access !== 1'b0 || mem_in_a.addr !== 32'h10) begin
          n_fail++; $display("FAIL churn_resp: got req=%b addr=%h expected 0/10", mem_in_a.req_mem_access, mem_in_a.addr);
        end
        req0 = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_port(0, 1'b1, 32'h10, 32'h0, DiatRead, Dias32);
    @(negedge clk);
    n_checks++;
    if (mem_in_a.req_mem_access !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: got req_mem_access=%b expected 1", mem_in_a.req_mem_access);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (ack0_a !== 1'b0 || ack1_a !== 1'b0 || mem_in_a !== '0 || rdata0_a !== 32'h0) begin
      n_fail++; $display("FAIL areset_now: got ack=%b%b mem_in=%h rdata0=%h expected all 0", ack0_a, ack1_a, mem_in_a, rdata0_a);
    end
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      n_checks++;
      if (ack0_a !== 1'b0 || ack1_a !== 1'b0) begin
        n_fail++; $display("FAIL areset_quiet c=%0d: got ack=%b%b expected 00", c, ack0_a, ack1_a);
      end
    end
    set_port(1, 1'b1, 32'h10, 32'h0, DiatRead, Dias32);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      n_checks++;
      if (ack1_a !== 1'(c == 2) || ack0_a !== 1'b0) begin
        n_fail++; $display("FAIL areset_after c=%0d: got ack=%b%b expected 0%b", c, ack0_a, ack1_a, c == 2);
      end
      if (c == 2) begin
        n_checks++;
        if (rdata1_a !== 32'h11223344) begin
          n_fail++; $display("FAIL areset_after_data: got %h expected 11223344", rdata1_a);
        end
        req1 = 1'b0;
      end
    end
  endtask

  // Random requesters checked against a transaction-level model: the
  // arbiter is free every third cycle, winners follow the round-robin rule.
  task automatic test_random();
    int                 free_at, exp_cyc;
    logic               last, exp_port, exp_rd, have_exp, e0, e1, w;
    logic               pend [2];
    logic               granted [2];
    logic [31:0]        pa [2];
    logic [31:0]        pd [2];
    DataInoutAccessType pt [2];
    DataInoutAccessSize ps [2];
    logic [31:0]        exp_data;
    logic [31:0]        got;
    logic               rq;
    do_reset();
    for (int i = 0; i < 65536; i++) mm[2][i] = mm[0][i];
    free_at = 0; last = 1'b1; have_exp = 1'b0; exp_cyc = 0; exp_port = 1'b0;
    exp_rd = 1'b0; exp_data = '0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; granted[p] = 1'b0; pa[p] = '0; pd[p] = '0;
      pt[p] = DiatRead; ps[p] = Dias32;
    end
    for (int k = 0; k < 900; k++) begin
      if (k > 0) @(negedge clk);
      e0 = have_exp && exp_cyc == k && exp_port == 1'b0;
      e1 = have_exp && exp_cyc == k && exp_port == 1'b1;
      n_checks++;
      if (ack0_a !== e0 || ack1_a !== e1) begin
        n_fail++; $display("FAIL rand_ack k=%0d: got %b%b expected %b%b", k, ack0_a, ack1_a, e0, e1);
      end
      if ((e0 || e1) && exp_rd) begin
        got = exp_port ? rdata1_a : rdata0_a;
        n_checks++;
        if (got !== exp_data || (exp_port ? rdata0_a : rdata1_a) !== 32'h0) begin
          n_fail++; $display("FAIL rand_rdata k=%0d port=%0d: got %h expected %h", k, exp_port, got, exp_data);
        end
      end
      if (have_exp && exp_cyc == k) begin
        pend[exp_port] = 1'b0; granted[exp_port] = 1'b0; have_exp = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && granted[p]) begin
          pa[p] = $urandom; pd[p] = $urandom;
        end else if (pend[p] && $urandom_range(15) == 0) begin
          pend[p] = 1'b0;
        end else if (!pend[p] && $urandom_range(1) == 1) begin
          pend[p] = 1'b1;
          pa[p] = {$urandom_range(3) == 0 ? 16'($urandom) : 16'h0, 8'h0, 8'($urandom)};
          pd[p] = $urandom;
          pt[p] = $urandom_range(1) ? DiatWrite : DiatRead;
          case ($urandom_range(2))
            0: ps[p] = Dias32;
            1: ps[p] = Dias16;
            default: ps[p] = Dias8;
          endcase
        end
        rq = pend[p] && (!granted[p] || $urandom_range(1) == 1);
        set_port(p, rq, pa[p], pd[p], pt[p], ps[p]);
      end
      if (k >= free_at && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) w = ~last;
        else                    w = pend[1];
        granted[w] = 1'b1; last = w;
        have_exp = 1'b1; exp_cyc = k + 2; free_at = k + 3; exp_port = w;
        exp_rd = (pt[w] == DiatRead);
        if (exp_rd) exp_data = mm_read(2, pa[w], ps[w]);
        else        mm_write(2, pa[w], pd[w], ps[w]);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    set_port(0, 1'b0, 32'h0, 32'h0, DiatRead, Dias32);
    set_port(1, 1'b0, 32'h0, 32'h0, DiatRead, Dias32);
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 65536; i++) mm[w][i] = 8'h00;
      mm_write(w, 32'h10, 32'h11223344, Dias32);
      mm_write(w, 32'h40, 32'hAABBCCDD, Dias32);
    end
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_input_churn();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
